// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and the instruction memory.
// The fetch stage is the master: it raises imem_req with a stable imem_addr and
// waits for the memory to answer with imem_ack and the instruction word.
interface fetch_unit_if #(
  parameter int PC_W = 8
);

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the PC, fetches one 32-bit word per instruction over the req/ack bus,
// presents it to the control path, and selects the next PC from the resolved
// control decisions (halt > jr > jump/jal > taken branch > sequential).
// Also keeps a saturating retired-instruction counter.
//
// Optional feature, enabled by defining FETCH_RESUME_EN:
//   adds a 'resume' input that leaves HALTED and fetches at PC+1.
//   Without the macro, HALTED is left only through reset.
module fetch_unit #(
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic             clock,
  input  logic             reset,
  fetch_unit_if.master     imem,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  link_addr,
  input  logic             exec_done,
  input  logic             jump,
  input  logic             jr,
  input  logic             branch,
  input  logic             br_taken,
  input  logic             halt,
  input  logic [15:0]      imm,
  input  logic [31:0]      rs_value,
`ifdef FETCH_RESUME_EN
  input  logic             resume,
`endif
  output logic             halted,
  output logic [31:0]      instret
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } state_t;

  state_t          state_q;
  state_t          state_d;

  logic [PC_W-1:0] pc_q;
  logic [31:0]     instr_q;
  logic [31:0]     instret_q;

  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] next_pc;
  logic [31:0]     imm_zext;
  logic [31:0]     imm_sext;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] jr_target;
  logic [PC_W-1:0] branch_target;
  logic            retire;
  logic            unused_inputs;

  // Only the low PC_W bits of the jump/JR operands reach the PC; the XOR keeps
  // the discarded upper bits visibly consumed.
  assign unused_inputs = ^{imm, rs_value};

  assign pc_plus1      = pc_q + PC_W'(1);
  assign imm_zext      = {16'h0000, imm};
  assign imm_sext      = {{16{imm[15]}}, imm};
  assign jump_target   = imm_zext[PC_W-1:0];
  assign jr_target     = rs_value[PC_W-1:0];
  assign branch_target = pc_plus1 + imm_sext[PC_W-1:0];

  // An instruction retires on the cycle the execute path reports completion.
  assign retire = (state_q == ISSUE) && exec_done;

  // Resolve the next PC strictly by priority; all sums wrap modulo 2**PC_W.
  always_comb begin
    next_pc = pc_plus1;
    if (halt) begin
      next_pc = pc_q;
    end else if (jr) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = jump_target;
    end else if (branch && br_taken) begin
      next_pc = branch_target;
    end
  end

  // State register; reset returns to IDLE so any ack still in flight is dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fetch, wait for execute, then either fetch again or park.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (exec_done) begin
          state_d = halt ? HALTED : FETCH;
        end
      end
      HALTED: begin
`ifdef FETCH_RESUME_EN
        if (resume) begin
          state_d = FETCH;
        end
`else
        state_d = HALTED;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers: capture the fetched word, advance the PC on retire,
  // and count retirements without wrapping past all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= PC_W'(RESET_PC);
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      if ((state_q == FETCH) && imem.imem_ack) begin
        instr_q <= imem.imem_rdata;
      end
      if (retire) begin
        pc_q <= next_pc;
        if (instret_q != 32'hFFFF_FFFF) begin
          instret_q <= instret_q + 32'd1;
        end
      end
`ifdef FETCH_RESUME_EN
      if ((state_q == HALTED) && resume) begin
        pc_q <= pc_plus1;
      end
`endif
    end
  end

  assign imem.imem_req  = (state_q == FETCH);
  assign imem.imem_addr = pc_q;

  assign instr       = instr_q;
  assign instr_valid = (state_q == ISSUE);
  assign pc          = pc_q;
  assign link_addr   = pc_plus1;
  assign halted      = (state_q == HALTED);
  assign instret     = instret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with PC_W=8, RESET_PC=0.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_fetch_unit;

  localparam int PC_W = 8;

  logic            clock;
  logic            reset;
  logic [31:0]     instr;
  logic            instr_valid;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] link_addr;
  logic            exec_done;
  logic            jump;
  logic            jr;
  logic            branch;
  logic            br_taken;
  logic            halt;
  logic [15:0]     imm;
  logic [31:0]     rs_value;
  logic            halted;
  logic [31:0]     instret;
`ifdef FETCH_RESUME_EN
  logic            resume;
`endif

  int tests;
  int failed;

  fetch_unit_if #(.PC_W(PC_W)) imem_bus ();

  fetch_unit #(
    .PC_W     (PC_W),
    .RESET_PC (0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imem        (imem_bus.master),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .link_addr   (link_addr),
    .exec_done   (exec_done),
    .jump        (jump),
    .jr          (jr),
    .branch      (branch),
    .br_taken    (br_taken),
    .halt        (halt),
    .imm         (imm),
    .rs_value    (rs_value),
`ifdef FETCH_RESUME_EN
    .resume      (resume),
`endif
    .halted      (halted),
    .instret     (instret)
  );

  // Free-running clock, period 10.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ed, input logic j, input logic r,
                               input logic b, input logic bt, input logic h,
                               input logic [15:0] im, input logic [31:0] rs);
    exec_done = ed;
    jump      = j;
    jr        = r;
    branch    = b;
    br_taken  = bt;
    halt      = h;
    imm       = im;
    rs_value  = rs;
  endtask

  // One-cycle ack with the given word; leaves the DUT in ISSUE.
  task automatic fetchWord(input logic [31:0] word);
    imem_bus.imem_ack   = 1'b1;
    imem_bus.imem_rdata = word;
    step();
    imem_bus.imem_ack   = 1'b0;
  endtask

  // One-cycle exec_done with the given control decisions, then idle controls.
  task automatic retireWith(input logic j, input logic r, input logic b,
                            input logic bt, input logic h, input logic [15:0] im,
                            input logic [31:0] rs);
    applyStimulus(1'b1, j, r, b, bt, h, im, rs);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b1;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
`ifdef FETCH_RESUME_EN
    resume = 1'b0;
`endif

    // 1: reset held three cycles, then released.
    step(); step(); step();
    checkOutput("rst_req",     {31'b0, imem_bus.imem_req}, 32'd0);
    checkOutput("rst_valid",   {31'b0, instr_valid}, 32'd0);
    checkOutput("rst_halted",  {31'b0, halted}, 32'd0);
    checkOutput("rst_instret", instret, 32'd0);
    checkOutput("rst_pc",      {24'b0, pc}, 32'd0);
    checkOutput("rst_instr",   instr, 32'd0);
    reset = 1'b0;
    checkOutput("idle_req", {31'b0, imem_bus.imem_req}, 32'd0);
    step();
    checkOutput("fetch_req",  {31'b0, imem_bus.imem_req}, 32'd1);
    checkOutput("fetch_addr", {24'b0, imem_bus.imem_addr}, 32'd0);

    // 2: slow ack; stray control activity during FETCH must be ignored.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0077, 32'h0);
    step();
    checkOutput("wait1_addr", {24'b0, imem_bus.imem_addr}, 32'd0);
    checkOutput("wait1_req",  {31'b0, imem_bus.imem_req}, 32'd1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
    checkOutput("wait2_addr",    {24'b0, imem_bus.imem_addr}, 32'd0);
    checkOutput("wait2_instret", instret, 32'd0);
    fetchWord(32'h0000_0000);
    checkOutput("issue_valid", {31'b0, instr_valid}, 32'd1);
    checkOutput("issue_req",   {31'b0, imem_bus.imem_req}, 32'd0);
    checkOutput("issue_instr", instr, 32'h0000_0000);
    retireWith(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
    checkOutput("seq_req",     {31'b0, imem_bus.imem_req}, 32'd1);
    checkOutput("seq_addr",    {24'b0, imem_bus.imem_addr}, 32'd1);
    checkOutput("seq_instret", instret, 32'd1);
    checkOutput("seq_valid",   {31'b0, instr_valid}, 32'd0);

    // 3: reach pc=5, then JAL to 0x20.
    fetchWord(32'h0800_0005);
    retireWith(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 32'h0);
    checkOutput("j5_addr", {24'b0, imem_bus.imem_addr}, 32'd5);
    fetchWord(32'h0C00_0020);
    checkOutput("jal_instr", instr, 32'h0C00_0020);
    checkOutput("jal_pc",    {24'b0, pc}, 32'd5);
    checkOutput("jal_link",  {24'b0, link_addr}, 32'd6);
    retireWith(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0020, 32'h0);
    checkOutput("jal_addr",    {24'b0, imem_bus.imem_addr}, 32'h20);
    checkOutput("jal_instret", instret, 32'd3);

    // 4: branches at pc=10 (second jump uses an immediate with high bits set).
    fetchWord(32'h0);
    retireWith(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h000A, 32'h0);
    fetchWord(32'h1000_FFFD);
    retireWith(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hFFFD, 32'h0);
    checkOutput("br_taken_addr", {24'b0, imem_bus.imem_addr}, 32'd8);
    fetchWord(32'h0);
    retireWith(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'hAB0A, 32'h0);
    checkOutput("jtrunc_addr", {24'b0, imem_bus.imem_addr}, 32'd10);
    fetchWord(32'h1000_FFFD);
    retireWith(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFD, 32'h0);
    checkOutput("br_nt_addr", {24'b0, imem_bus.imem_addr}, 32'd11);
    fetchWord(32'h0);
    retireWith(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0044, 32'hFFFF_FF33);
    checkOutput("jr_addr",    {24'b0, imem_bus.imem_addr}, 32'h33);
    checkOutput("jr_instret", instret, 32'd8);

    // 5: wrap at 0xFF, then halt (halt outranks a simultaneous jump).
    fetchWord(32'h0);
    retireWith(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h00FF, 32'h0);
    fetchWord(32'h0);
    checkOutput("wrap_link", {24'b0, link_addr}, 32'd0);
    retireWith(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h0);
    checkOutput("wrap_addr", {24'b0, imem_bus.imem_addr}, 32'd0);
    fetchWord(32'hFC00_0000);
    retireWith(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0055, 32'h0);
    checkOutput("halt_halted",  {31'b0, halted}, 32'd1);
    checkOutput("halt_req",     {31'b0, imem_bus.imem_req}, 32'd0);
    checkOutput("halt_valid",   {31'b0, instr_valid}, 32'd0);
    checkOutput("halt_pc",      {24'b0, pc}, 32'd0);
    checkOutput("halt_instret", instret, 32'd11);
    imem_bus.imem_ack = 1'b1;
    step(); step(); step();
    imem_bus.imem_ack = 1'b0;
    checkOutput("hold_halted", {31'b0, halted}, 32'd1);
    checkOutput("hold_req",    {31'b0, imem_bus.imem_req}, 32'd0);
    checkOutput("hold_pc",     {24'b0, pc}, 32'd0);

    // 6: reset during a FETCH wait at 0x40; the late ack must be ignored.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    fetchWord(32'h0);
    retireWith(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 32'h0);
    checkOutput("pre_rst_addr", {24'b0, imem_bus.imem_addr}, 32'h40);
    reset = 1'b1;
    step();
    reset = 1'b0;
    fetchWord(32'hDEAD_BEEF);
    checkOutput("late_ack_valid",   {31'b0, instr_valid}, 32'd0);
    checkOutput("late_ack_instr",   instr, 32'd0);
    checkOutput("late_ack_instret", instret, 32'd0);
    checkOutput("late_ack_halted",  {31'b0, halted}, 32'd0);
    step();
    checkOutput("restart_req",  {31'b0, imem_bus.imem_req}, 32'd1);
    checkOutput("restart_addr", {24'b0, imem_bus.imem_addr}, 32'd0);

`ifdef FETCH_RESUME_EN
    // Resume from HALTED at pc=7 fetches at 8 without retiring anything.
    fetchWord(32'h0);
    retireWith(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0007, 32'h0);
    fetchWord(32'h0);
    retireWith(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 32'h0);
    checkOutput("res_halted_before", {31'b0, halted}, 32'd1);
    resume = 1'b1;
    step();
    resume = 1'b0;
    checkOutput("res_halted",  {31'b0, halted}, 32'd0);
    checkOutput("res_req",     {31'b0, imem_bus.imem_req}, 32'd1);
    checkOutput("res_addr",    {24'b0, imem_bus.imem_addr}, 32'd8);
    checkOutput("res_instret", instret, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
